// File: rtl/ctrl_pkg.sv
// Shared opcode and state-code definitions for the control sequencer.
// Pure declarations with no timing of their own.
// No handshake is involved here; the state values are the legacy 5-bit datapath codes.
package ctrl_pkg;

    localparam logic [3:0] OP_LOAD    = 4'd0;
    localparam logic [3:0] OP_MOVE    = 4'd1;
    localparam logic [3:0] OP_LDPC    = 4'd2;
    localparam logic [3:0] OP_BRANCH  = 4'd3;
    localparam logic [3:0] OP_ADD     = 4'd4;
    localparam logic [3:0] OP_XOR     = 4'd5;
    localparam logic [3:0] OP_SUB     = 4'd6;
    localparam logic [3:0] OP_MUL     = 4'd7;
    localparam logic [3:0] OP_DIV     = 4'd8;
    localparam logic [3:0] OP_ONES    = 4'd9;
    localparam logic [3:0] OP_ONESALL = 4'd10;

    typedef enum logic [4:0] {
        S_IDLE     = 5'b00000,
        S_LOAD     = 5'b00001,
        S_MOVE     = 5'b00010,
        S_LDPC     = 5'b00011,
        S_BRANCH   = 5'b00100,
        S_ADD1     = 5'b00101,
        S_ADD2     = 5'b00110,
        S_ADD3     = 5'b00111,
        S_XOR1     = 5'b01000,
        S_XOR2     = 5'b01001,
        S_XOR3     = 5'b01010,
        S_SUB1     = 5'b01011,
        S_SUB2     = 5'b01100,
        S_SUB3     = 5'b01101,
        S_MUL1     = 5'b01110,
        S_MUL2     = 5'b01111,
        S_MUL3     = 5'b10000,
        S_DIV1     = 5'b10001,
        S_DIV2     = 5'b10010,
        S_DIV3     = 5'b10011,
        S_ONES1    = 5'b10100,
        S_ONES2    = 5'b10101,
        S_ONES3    = 5'b10110,
        S_ONESALL1 = 5'b10111,
        S_ONESALL2 = 5'b11000,
        S_ONESALL3 = 5'b11001,
        S_ONESALL4 = 5'b11010,
        S_ONESALL5 = 5'b11011,
        S_ONESALL6 = 5'b11100,
        S_ONESALL7 = 5'b11101
    } state_e;

    function automatic logic is_terminal(input state_e s);
        case (s)
            S_LOAD, S_MOVE, S_LDPC, S_BRANCH, S_ADD3, S_XOR3, S_SUB3,
            S_MUL3, S_DIV3, S_ONES3, S_ONESALL7: is_terminal = 1'b1;
            default:                             is_terminal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/loop_counter.sv
// Down-counter for the onesAll register walk, with load, decrement and zero flag.
// The count updates one cycle after clr/load/dec, and the zero flag follows it combinationally.
// No backpressure: clr overrides load, and load overrides dec.
module loop_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ctrl_sequencer.sv
// Registered control sequencer: accepts one instruction and walks its legacy state chain.
// The first state appears 1 cycle after accept, and done is asserted during the terminal state.
// instr_ready is high only in IDLE without abort; mul2/div2 can stall on alu_done.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int INSTR_W      = 16,
    parameter int NREGS        = 16,
    parameter int CNT_W        = $clog2(NREGS),
    parameter bit MULDIV_STALL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               alu_done,
    input  logic               abort,
    output logic [4:0]         state,
    output logic [3:0]         opcode_q,
    output logic [CNT_W-1:0]   reg_idx,
    output logic               done,
    output logic               illegal_op
);

    state_e           st_q, st_d;
    logic             accept;
    logic             illegal_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_in;
    logic             unused_instr;

    assign op_in        = instr[INSTR_W-1 -: 4];
    assign unused_instr = ^instr[INSTR_W-5:0];
    assign instr_ready  = (st_q == S_IDLE) && !abort;
    assign accept       = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q       <= S_IDLE;
            opcode_q   <= '0;
            illegal_op <= 1'b0;
        end else begin
            st_q       <= st_d;
            illegal_op <= illegal_d;
            if (accept) begin
                opcode_q <= op_in;
            end
        end
    end

    always_comb begin
        st_d      = S_IDLE;
        illegal_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        if (!abort) begin
            case (st_q)
                S_IDLE: begin
                    if (accept) begin
                        case (op_in)
                            OP_LOAD:    st_d = S_LOAD;
                            OP_MOVE:    st_d = S_MOVE;
                            OP_LDPC:    st_d = S_LDPC;
                            OP_BRANCH:  st_d = S_BRANCH;
                            OP_ADD:     st_d = S_ADD1;
                            OP_XOR:     st_d = S_XOR1;
                            OP_SUB:     st_d = S_SUB1;
                            OP_MUL:     st_d = S_MUL1;
                            OP_DIV:     st_d = S_DIV1;
                            OP_ONES:    st_d = S_ONES1;
                            OP_ONESALL: st_d = S_ONESALL1;
                            default:    illegal_d = 1'b1;
                        endcase
                    end
                end
                S_ADD1:  st_d = S_ADD2;
                S_ADD2:  st_d = S_ADD3;
                S_XOR1:  st_d = S_XOR2;
                S_XOR2:  st_d = S_XOR3;
                S_SUB1:  st_d = S_SUB2;
                S_SUB2:  st_d = S_SUB3;
                S_MUL1:  st_d = S_MUL2;
                S_MUL2:  st_d = (!MULDIV_STALL || alu_done) ? S_MUL3 : S_MUL2;
                S_DIV1:  st_d = S_DIV2;
                S_DIV2:  st_d = (!MULDIV_STALL || alu_done) ? S_DIV3 : S_DIV2;
                S_ONES1: st_d = S_ONES2;
                S_ONES2: st_d = S_ONES3;
                S_ONESALL1: begin
                    st_d     = S_ONESALL2;
                    cnt_load = 1'b1;
                end
                S_ONESALL2: st_d = S_ONESALL3;
                S_ONESALL3: st_d = cnt_zero ? S_ONESALL7 : S_ONESALL4;
                S_ONESALL4: st_d = S_ONESALL5;
                S_ONESALL5: st_d = S_ONESALL6;
                S_ONESALL6: begin
                    st_d    = S_ONESALL3;
                    cnt_dec = 1'b1;
                end
                // Terminal states and the two unused codes all fall back to IDLE.
                default: st_d = S_IDLE;
            endcase
        end
    end

    loop_counter #(
        .CNT_W(CNT_W)
    ) u_loop_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (abort),
        .load     (cnt_load),
        .load_val (CNT_W'(NREGS - 1)),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Iterations count down from NREGS-1, so this maps them to r1 upward.
    assign reg_idx = cnt_zero ? '0 : CNT_W'(NREGS - int'(cnt));
    assign state   = st_q;
    assign done    = is_terminal(st_q);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed-vector bench for ctrl_sequencer: one 16-register instance and one 4-register instance share the stimulus.
// Every expected value is hand-derived from the state-sequence rules.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        alu_done;
    logic        abort;

    logic       rdy16, done16, ill16, rdy4, done4, ill4;
    logic [4:0] s16, s4;
    logic [3:0] op16, op4;
    logic [3:0] ri16;
    logic [1:0] ri4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.INSTR_W(16), .NREGS(16), .MULDIV_STALL(1'b1)) dut16 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(rdy16), .alu_done(alu_done), .abort(abort), .state(s16),
        .opcode_q(op16), .reg_idx(ri16), .done(done16), .illegal_op(ill16)
    );

    ctrl_sequencer #(.INSTR_W(16), .NREGS(4), .MULDIV_STALL(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(rdy4), .alu_done(alu_done), .abort(abort), .state(s4),
        .opcode_q(op4), .reg_idx(ri4), .done(done4), .illegal_op(ill4)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_state16(input logic [4:0] target, input int budget);
        int k;
        k = 0;
        while (s16 !== target && k < budget) begin
            tick();
            k++;
        end
        if (s16 !== target) check_eq("wait_timeout", 32'(s16), 32'(target));
    endtask

    initial begin
        int cyc16, cyc4, it16, it4;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; alu_done = 1'b0; abort = 1'b0;
        tick(); tick();
        check_eq("rst_state", 32'(s16), 32'h00);
        check_eq("rst_opcode", 32'(op16), 32'h0);
        check_eq("rst_done", 32'(done16), 32'h0);
        check_eq("rst_illegal", 32'(ill16), 32'h0);
        check_eq("rst_ready", 32'(rdy16), 32'h1);
        check_eq("rst_regidx", 32'(ri16), 32'h0);
        rst_n = 1'b1;
        tick();

        // add: three-step chain
        issue(16'h4123);
        check_eq("add_s1", 32'(s16), 32'h05);
        check_eq("add_op", 32'(op16), 32'h4);
        check_eq("add_rdy1", 32'(rdy16), 32'h0);
        check_eq("add_done1", 32'(done16), 32'h0);
        tick();
        check_eq("add_s2", 32'(s16), 32'h06);
        check_eq("add_rdy2", 32'(rdy16), 32'h0);
        tick();
        check_eq("add_s3", 32'(s16), 32'h07);
        check_eq("add_done3", 32'(done16), 32'h1);
        check_eq("add_rdy3", 32'(rdy16), 32'h0);
        tick();
        check_eq("add_idle", 32'(s16), 32'h00);
        check_eq("add_rdy_idle", 32'(rdy16), 32'h1);
        check_eq("add_done_idle", 32'(done16), 32'h0);

        // alu_done in IDLE is ignored
        alu_done = 1'b1;
        tick();
        check_eq("alu_idle_ignored", 32'(s16), 32'h00);
        alu_done = 1'b0;

        // mul: stall in 01111 for 6 cycles, alu_done arriving in the 6th
        issue(16'h7000);
        check_eq("mul_s1", 32'(s16), 32'h0E);
        tick();
        check_eq("mul_stall_c1", 32'(s16), 32'h0F);
        for (int i = 2; i <= 6; i++) begin
            tick();
            check_eq($sformatf("mul_stall_c%0d", i), 32'(s16), 32'h0F);
            check_eq("mul_stall_nodone", 32'(done16), 32'h0);
        end
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check_eq("mul_s3", 32'(s16), 32'h10);
        check_eq("mul_done", 32'(done16), 32'h1);
        tick();
        check_eq("mul_idle", 32'(s16), 32'h00);

        // onesAll on both instances: NREGS-1 iterations, reg_idx walks 1..NREGS-1
        issue(16'hA000);
        check_eq("oa_first16", 32'(s16), 32'h17);
        check_eq("oa_first4", 32'(s4), 32'h17);
        cyc16 = 0; cyc4 = 0; it16 = 0; it4 = 0;
        for (int k = 0; k < 200 && (s16 != 5'h00 || s4 != 5'h00); k++) begin
            if (s16 != 5'h00) begin
                cyc16++;
                if (s16 == 5'h1A) begin
                    it16++;
                    check_eq("oa_idx16", 32'(ri16), 32'(it16));
                end
                if (s16 == 5'h1D) check_eq("oa_done16", 32'(done16), 32'h1);
            end
            if (s4 != 5'h00) begin
                cyc4++;
                if (s4 == 5'h1A) begin
                    it4++;
                    check_eq("oa_idx4", 32'(ri4), 32'(it4));
                end
                if (s4 == 5'h1D) check_eq("oa_done4", 32'(done4), 32'h1);
            end
            tick();
        end
        check_eq("oa_iters16", 32'(it16), 32'd15);
        check_eq("oa_iters4", 32'(it4), 32'd3);
        // 10111 + 11000 + 4 per iteration + final 11001 + 11101
        check_eq("oa_cycles16", 32'(cyc16), 32'd64);
        check_eq("oa_cycles4", 32'(cyc4), 32'd16);
        check_eq("oa_end_state", 32'(s16), 32'h00);
        check_eq("oa_end_idx", 32'(ri16), 32'h0);

        // illegal opcode consumed, then a normal load
        issue(16'hC000);
        check_eq("ill_pulse", 32'(ill16), 32'h1);
        check_eq("ill_state", 32'(s16), 32'h00);
        check_eq("ill_done", 32'(done16), 32'h0);
        check_eq("ill_opcode", 32'(op16), 32'hC);
        tick();
        check_eq("ill_pulse_end", 32'(ill16), 32'h0);
        issue(16'h0000);
        check_eq("load_state", 32'(s16), 32'h01);
        check_eq("load_done", 32'(done16), 32'h1);
        check_eq("load_no_ill", 32'(ill16), 32'h0);
        tick();
        check_eq("load_idle", 32'(s16), 32'h00);

        // abort in 11011 mid-onesAll, then abort blocking an offer in IDLE
        issue(16'hA000);
        wait_state16(5'h1B, 20);
        check_eq("abt_idx_before", 32'(ri16), 32'h1);
        abort = 1'b1;
        check_eq("abt_rdy_low", 32'(rdy16), 32'h0);
        tick();
        check_eq("abt_state", 32'(s16), 32'h00);
        check_eq("abt_done", 32'(done16), 32'h0);
        check_eq("abt_cnt_clear", 32'(ri16), 32'h0);
        check_eq("abt_idle_rdy", 32'(rdy16), 32'h0);
        issue(16'h4000);
        check_eq("abt_no_accept", 32'(s16), 32'h00);
        check_eq("abt_opcode_kept", 32'(op16), 32'hA);
        abort = 1'b0;
        tick();

        // reset while stalled in 01111
        issue(16'h7000);
        tick();
        check_eq("rstmid_pre", 32'(s16), 32'h0F);
        rst_n = 1'b0;
        tick();
        check_eq("rstmid_state", 32'(s16), 32'h00);
        check_eq("rstmid_done", 32'(done16), 32'h0);
        check_eq("rstmid_opcode", 32'(op16), 32'h0);
        rst_n = 1'b1;
        tick();
        issue(16'h2000);
        check_eq("ldpc_state", 32'(s16), 32'h03);
        check_eq("ldpc_done", 32'(done16), 32'h1);
        tick();
        check_eq("ldpc_idle", 32'(s16), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
